// File: rtl/spi_pkg.sv
// Shared definitions for the SPI request arbiter: engine register bit
// positions, arbiter state encoding and a control-word builder.
package spi_pkg;

    localparam int SPI_START_BIT = 31;
    localparam int SPI_BUSY_BIT  = 31;
    localparam int SPI_NBITS_LSB = 0;
    localparam int SPI_NBITS_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_t;

    // Engine control word: start level in bit 31, transfer length in the low field.
    function automatic logic [31:0] make_control(input logic start,
                                                 input logic [SPI_NBITS_W-1:0] nbits);
        logic [31:0] c;
        c = '0;
        c[SPI_START_BIT] = start;
        c[SPI_NBITS_LSB +: SPI_NBITS_W] = nbits;
        return c;
    endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Bundle of requester, response and engine-side signals of the arbiter.
// slave is the arbiter's view, master the view of everything around it.
interface spi_req_arbiter_if #(
    parameter int NREQ = 3,
    parameter int IDW  = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*6-1:0]  req_nbits;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic [31:0]        spi_control;
    logic [31:0]        spi_wrdata;
    logic [31:0]        spi_rddata;
    logic [31:0]        spi_status;

    modport slave (
        input  req_valid, req_wdata, req_nbits, rsp_ready, spi_rddata, spi_status,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, spi_control, spi_wrdata
    );

    modport master (
        output req_valid, req_wdata, req_nbits, rsp_ready, spi_rddata, spi_status,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, spi_control, spi_wrdata
    );
endinterface

// File: rtl/spi_req_arbiter_rr.sv
// Combinational round-robin picker: the first requester strictly after ptr
// (wrapping modulo NREQ) wins. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    logic           hi_hit;
    logic           lo_hit;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;

    // Lowest active index above ptr has priority; otherwise wrap to lowest overall.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_hit = 1'b1;
                lo_idx = IDW'(k);
                if (k > int'(ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = IDW'(k);
                end
            end
        end
    end

    assign any = en & lo_hit;
    assign idx = hi_hit ? hi_idx : lo_idx;

    // Expand the winning index into a one-hot grant, gated by enable.
    always_comb begin
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            grant[k] = any && (idx == IDW'(k));
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI engine between NREQ requesters: round-robin grant, start/busy
// handshake with start and busy watchdogs, tagged response with backpressure.
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int IDW        = 3,
    parameter int START_WAIT = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic             clk,
    input  logic             reset,
    spi_req_arbiter_if.slave bus
);
    localparam int CNT_MAX = (START_WAIT > TIMEOUT) ? START_WAIT : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_WAIT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state, state_n;
    logic [IDW-1:0]   ptr, ptr_n;
    logic [IDW-1:0]   id_q, id_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [31:0]      ctrl_q, ctrl_n;
    logic [31:0]      wdata_q, wdata_n;
    logic [31:0]      rdata_q, rdata_n;
    logic             err_q, err_n;

    logic             arb_en;
    logic             arb_any;
    logic [NREQ-1:0]  arb_grant;
    logic [IDW-1:0]   arb_idx;
    logic [31:0]      sel_wdata;
    logic [SPI_NBITS_W-1:0] sel_nbits;
    logic             busy;
    logic             unused_status;

    assign busy          = bus.spi_status[SPI_BUSY_BIT];
    assign unused_status = ^bus.spi_status[30:0];

    // Grants only happen in IDLE and never while reset is held, so req_ready is 0 in reset.
    assign arb_en = (state == ST_IDLE) && reset;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    // Select the granted requester's write word and transfer length.
    always_comb begin
        sel_wdata = '0;
        sel_nbits = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_grant[k]) begin
                sel_wdata = bus.req_wdata[32*k +: 32];
                sel_nbits = bus.req_nbits[SPI_NBITS_W*k +: SPI_NBITS_W];
            end
        end
    end

    // Next-state and next-register values for the transfer sequencer.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        id_n    = id_q;
        cnt_n   = cnt;
        ctrl_n  = ctrl_q;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        err_n   = err_q;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_n = ST_START;
                    ptr_n   = arb_idx;
                    id_n    = arb_idx;
                    wdata_n = sel_wdata;
                    ctrl_n  = make_control(1'b1, sel_nbits);
                    cnt_n   = '0;
                    rdata_n = '0;
                    err_n   = 1'b0;
                end
            end
            ST_START: begin
                // A busy that is already high (stale engine) also counts as the handshake.
                if (busy) begin
                    state_n = ST_WAIT_DONE;
                    cnt_n   = '0;
                    ctrl_n[SPI_START_BIT] = 1'b0;
                end else if (cnt >= START_LAST) begin
                    state_n = ST_RESP;
                    ctrl_n  = '0;
                    rdata_n = '0;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy) begin
                    state_n = ST_RESP;
                    ctrl_n  = '0;
                    rdata_n = bus.spi_rddata;
                    err_n   = 1'b0;
                end else if (cnt >= TIMEOUT_LAST) begin
                    state_n = ST_RESP;
                    ctrl_n  = '0;
                    rdata_n = '0;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Register update; reset abandons any transfer without producing a response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            ptr     <= IDW'(NREQ - 1);
            id_q    <= '0;
            cnt     <= '0;
            ctrl_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            id_q    <= id_n;
            cnt     <= cnt_n;
            ctrl_q  <= ctrl_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
        end
    end

    assign bus.req_ready   = arb_grant;
    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.rsp_id      = id_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.spi_control = ctrl_q;
    assign bus.spi_wrdata  = wdata_q;

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one spi_top SPI engine (ADC or PM channel) between NREQ independent requesters, e.g. host software and an autonomous poller.
- Sits between requesters and one engine's control/wrdata/rddata/status words.
- Grants requests round-robin, sequences the start/busy handshake, captures read data and returns it tagged with the requester ID.
- Applies a watchdog timeout so a hung engine cannot block other requesters.

Parameters:
- NREQ, 3, number of requesters (2..8).
- IDW, 3, requester ID width; must satisfy 2^IDW >= NREQ.
- START_WAIT, 16, max cycles from start assertion to engine busy rising.
- TIMEOUT, 4096, max cycles engine busy may stay high.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_wdata  in  NREQ*32  write word; requester i occupies bits [32i+31:32i].
- req_nbits  in  NREQ*6  transfer length; 0 means 32, 1..31 literal; requester i occupies bits [6i+5:6i].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  ID of the requester being answered.
- rsp_rdata  out  32  engine read data.
- rsp_err  out  1  1 = timeout; rsp_rdata is then 0.
- spi_control  out  32  to engine control: bit31 = start (level), bits[5:0] = nbits, all other bits 0.
- spi_wrdata  out  32  to engine write data.
- spi_rddata  in  32  from engine read data; valid once busy falls.
- spi_status  in  32  from engine status: bit31 = busy; other bits ignored.

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - state IDLE, rr pointer = NREQ-1;
  - all outputs 0: req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, spi_control, spi_wrdata.
  - Reset mid-transfer drops start immediately; the engine finishes or aborts on its own and no response is generated.
- IDLE:
  - If any req_valid, grant the first valid index searching (ptr+1 .. ptr+NREQ) mod NREQ.
  - In the same cycle: assert that requester's req_ready for exactly one cycle, latch wdata, nbits and ID, set ptr = granted index, go to START.
  - A requester that drops valid before grant is simply not served.
- START:
  - spi_control[31]=1, spi_wrdata=latched word, counter cleared.
  - Busy seen high -> WAIT_DONE.
  - Counter reaches START_WAIT -> RESP with err=1.
- WAIT_DONE:
  - start stays high until busy is seen, then is dropped the cycle after busy rises.
  - Busy falls -> capture spi_rddata into rsp_rdata, err=0 -> RESP.
  - Counter reaches TIMEOUT -> RESP with err=1, rdata=0, start dropped.
- RESP:
  - rsp_valid=1 with id/rdata/err stable until rsp_ready.
  - On the cycle rsp_valid&rsp_ready -> IDLE.
  - The next grant occurs at the earliest on the following cycle; one idle cycle minimum between transfers.
- Latency: grant to start = 1 cycle; busy fall to rsp_valid = 1 cycle.
- Simultaneous requests: strict round-robin. A continuously requesting source is served at most once per NREQ grants when others are pending.
- Busy already high on entry to START (stale engine) is treated as a valid handshake; this is documented, not an error.
- Counter: 13-bit saturating, width = clog2(max(START_WAIT, TIMEOUT)) + 1.

Decomposition:
- Shared package spi_pkg:
  - SPI_START_BIT=31, SPI_BUSY_BIT=31, SPI_NBITS_LSB=0, SPI_NBITS_W=6;
  - arbiter state encoding (IDLE, START, WAIT_DONE, RESP).
- One sub-module: rr_arbiter (NREQ-wide round-robin priority picker: req vector, ptr, en -> one-hot grant plus index). Combinational pick, pointer register kept in the parent.

Test Plan:
- Single request: req0 wdata=0xA5A5_0001, nbits=16; behavioural engine busy 20 cycles, rddata=0x0000_1234 -> spi_control=0x8000_0010 one cycle after grant; rsp_id=0, rsp_rdata=0x0000_1234, rsp_err=0.
- Contention: all three requesters held valid for 6 transfers -> grant order 0,1,2,0,1,2; each req_ready a single-cycle pulse.
- Start timeout: engine never raises busy -> after 16 cycles rsp_err=1, rsp_rdata=0, spi_control[31]=0; next request served normally.
- Busy timeout: busy stuck high -> rsp_err=1 after 4096 cycles; arbiter returns to IDLE.
- Backpressure: rsp_ready held low 50 cycles -> rsp_valid and rsp fields stable, no new grant; release -> next grant one cycle later.
- Reset in WAIT_DONE: reset low 1 cycle -> spi_control=0, rsp_valid=0, pointer reset so requester 0 wins next.
